mux_select_sequencer: RTL



---
 rtl/mux_seq_pkg.sv | 27 ++
 rtl/mux_select_sequencer.sv | 95 +++++++++
 2 files changed

// File: rtl/mux_seq_pkg.sv
// Shared types and index helpers for the 4:1 mux select sequencer.
// Selector ordering is folded into first/last/step helpers so the FSM stays order-agnostic.
package mux_seq_pkg;

    localparam int NUM_LINES = 4;
    localparam int SEL_W     = 2;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    function automatic logic [SEL_W-1:0] first_index(input bit msb_first);
        return msb_first ? SEL_W'(NUM_LINES - 1) : '0;
    endfunction

    function automatic logic [SEL_W-1:0] last_index(input bit msb_first);
        return msb_first ? '0 : SEL_W'(NUM_LINES - 1);
    endfunction

    // Only called before the last index, so the 2-bit step never wraps inside a word.
    function automatic logic [SEL_W-1:0] step_index(input logic [SEL_W-1:0] sel,
                                                    input bit msb_first);
        return msb_first ? sel - SEL_W'(1) : sel + SEL_W'(1);
    endfunction

endpackage

// File: rtl/mux_select_sequencer.sv
// Holds a 4-bit word on the mux data lines and walks the selector through every position,
// one position per consumed bit, with back-to-back reload on the final bit.
module mux_select_sequencer
    import mux_seq_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_LINES-1:0] word_in,
    input  logic                 word_valid,
    output logic                 word_ready,
    input  logic                 bit_ready,
    input  logic                 abort,
    output logic [NUM_LINES-1:0] input_lines,
    output logic [SEL_W-1:0]     selector_bits,
    output logic                 bit_valid,
    output logic                 last_bit,
    output logic                 busy
);

    // Handshakes: a word transfers on any rising edge where word_valid && word_ready;
    // a bit is consumed on any rising edge where bit_valid && bit_ready. Both ready
    // signals are combinational and abort masks word_ready in every state.

    localparam logic [SEL_W-1:0] FIRST_IDX = first_index(MSB_FIRST);
    localparam logic [SEL_W-1:0] LAST_IDX  = last_index(MSB_FIRST);

    state_t                 state, state_nxt;
    logic [SEL_W-1:0]       sel_q, sel_nxt;
    logic [NUM_LINES-1:0]   lines_q, lines_nxt;
    logic                   accept;
    logic                   consume;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            sel_q   <= '0;
            lines_q <= '0;
        end else begin
            state   <= state_nxt;
            sel_q   <= sel_nxt;
            lines_q <= lines_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        sel_nxt    = sel_q;
        lines_nxt  = lines_q;
        word_ready = 1'b0;
        bit_valid  = 1'b0;
        last_bit   = 1'b0;
        busy       = 1'b0;

        case (state)
            IDLE: begin
                word_ready = !abort;
            end
            SEND: begin
                bit_valid  = 1'b1;
                busy       = 1'b1;
                last_bit   = (sel_q == LAST_IDX);
                word_ready = last_bit && bit_ready && !abort;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        accept  = word_valid && word_ready;
        consume = bit_valid && bit_ready;

        // Abort wins over everything; the held word stays on the lines.
        if (abort) begin
            state_nxt = IDLE;
            sel_nxt   = '0;
        end else if (accept) begin
            state_nxt = SEND;
            sel_nxt   = FIRST_IDX;
            lines_nxt = word_in;
        end else if (consume) begin
            if (last_bit) begin
                state_nxt = IDLE;
                sel_nxt   = '0;
            end else begin
                sel_nxt = step_index(sel_q, MSB_FIRST);
            end
        end
    end

    assign input_lines   = lines_q;
    assign selector_bits = sel_q;

endmodule
